// File: rtl/bm_dag1_pkg.sv
// bm_dag1_pkg: shared constants, state enum and FIFO entry type for the dag1 result packer
// Optional feature macro: PACKER_PARITY_EN adds a stored even-parity bit to every FIFO entry.
package bm_dag1_pkg;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    localparam int N_BITS   = 2;
    localparam int N_PACK   = 4;
    localparam int N_DEPTH  = 4;
    localparam int SAMPLE_W = N_BITS + 1;
    localparam int WORD_W   = N_PACK * SAMPLE_W;
    localparam int FILL_W   = clog2(N_PACK + 1);
    localparam int LVL_W    = clog2(N_DEPTH + 1);
`ifdef PACKER_PARITY_EN
    localparam int OUT_W    = WORD_W + 1;
`else
    localparam int OUT_W    = WORD_W;
`endif
    typedef enum logic {PACK, FLUSH_PEND} packer_state_t;
    typedef struct packed {
`ifdef PACKER_PARITY_EN
        logic              parity;
`endif
        logic [FILL_W-1:0] fill;
        logic [WORD_W-1:0] word;
    } fifo_entry_t;
endpackage

// File: rtl/bm_dag1_word_fifo.sv
// bm_dag1_word_fifo: synchronous show-ahead FIFO with registered level
// Ports: clock, reset_n (sync, active-low), push/push_data, pop, head (entry at read pointer),
//        full, empty, level (0..DEPTH). DEPTH must be a power of two so pointers wrap naturally.
module bm_dag1_word_fifo
    import bm_dag1_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head,
    output logic                        full,
    output logic                        empty,
    output logic [clog2(DEPTH+1)-1:0]   level
);
    localparam int LW    = clog2(DEPTH + 1);
    localparam int PTR_W = clog2(DEPTH) < 1 ? 1 : clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(do_push);
            rd_ptr <= rd_ptr + PTR_W'(do_pop);
            level  <= level + LW'(do_push) - LW'(do_pop);
        end
    end
    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/bm_dag1_result_packer.sv
// bm_dag1_result_packer: packs dag1 (out1,out0) samples into wide words buffered in a FIFO
// Ports: clock, reset_n (sync, active-low); in_valid/in_ready/out0_in/out1_in sample input;
//        flush emits the partial word; word_out/word_fill/word_valid/word_ready FIFO head port;
//        fifo_level occupancy. Macro PACKER_PARITY_EN appends an even-parity MSB to word_out.
module bm_dag1_result_packer
    import bm_dag1_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] out0_in,
    input  logic              out1_in,
    input  logic              flush,
    output logic [OUT_W-1:0]  word_out,
    output logic [FILL_W-1:0] word_fill,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [LVL_W-1:0]  fifo_level
);
    packer_state_t     state;
    logic [FILL_W-1:0] count, fill_next;
    logic [WORD_W-1:0] slots, merged;
    logic              accept, last, flush_req, push, full, empty;
    fifo_entry_t       wr_entry, head;
    assign last      = count == FILL_W'(N_PACK - 1);
    assign in_ready  = state == PACK && (!full || !last);
    assign accept    = in_valid && in_ready;
    assign flush_req = state == PACK && flush && (count != '0 || accept);
    // the word as it stands after this cycle's sample, so every push path shares one datapath
    assign merged    = accept ? slots | (WORD_W'({out1_in, out0_in}) << (count * SAMPLE_W)) : slots;
    assign fill_next = count + FILL_W'(accept);
    // a full-word commit can never hit a full FIFO because in_ready is low for that slot
    assign push      = state == FLUSH_PEND ? !full : (accept && last) || (flush_req && !full);
    assign wr_entry.fill = fill_next;
    assign wr_entry.word = merged;
`ifdef PACKER_PARITY_EN
    assign wr_entry.parity = ^merged;
    assign word_out = empty ? '0 : {head.parity, head.word};
`else
    assign word_out = empty ? '0 : head.word;
`endif
    assign word_fill  = empty ? '0 : head.fill;
    assign word_valid = !empty;
    always_ff @(posedge clock) begin
        if (!reset_n || push) begin
            state <= PACK;
            count <= '0;
            slots <= '0;
        end else begin
            count <= fill_next;
            slots <= merged;
            if (flush_req) state <= FLUSH_PEND;
        end
    end
    bm_dag1_word_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(N_DEPTH)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (wr_entry),
        .pop       (word_ready && word_valid),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );
endmodule

// File: tb/tb_bm_dag1_result_packer.sv
// tb_bm_dag1_result_packer: directed and randomized checks against a queue-based packer model
module tb_bm_dag1_result_packer;
    import bm_dag1_pkg::*;
    logic              clock = 0, reset_n = 0, in_valid = 0, out1_in = 0, flush = 0, word_ready = 0;
    logic [N_BITS-1:0] out0_in = '0;
    logic              in_ready, word_valid;
    logic [OUT_W-1:0]  word_out;
    logic [FILL_W-1:0] word_fill;
    logic [LVL_W-1:0]  fifo_level;
    int checks = 0, errors = 0;
    typedef struct {logic [OUT_W-1:0] w; int f;} mw_t;
    int  cur[$];
    mw_t q[$];
    bit  pend;

    always #5 clock = ~clock;

    bm_dag1_result_packer dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .out0_in(out0_in), .out1_in(out1_in), .flush(flush), .word_out(word_out),
        .word_fill(word_fill), .word_valid(word_valid), .word_ready(word_ready),
        .fifo_level(fifo_level)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mw_t build();
        mw_t m;
        logic [WORD_W-1:0] d;
        d = '0;
        foreach (cur[k]) d |= WORD_W'(cur[k]) << (k * SAMPLE_W);
        m.f = cur.size();
`ifdef PACKER_PARITY_EN
        m.w = {^d, d};
`else
        m.w = d;
`endif
        return m;
    endfunction

    function automatic bit exp_ready();
        return !pend && !(q.size() == N_DEPTH && cur.size() == N_PACK - 1);
    endfunction

    task automatic step(bit iv, bit o1, logic [N_BITS-1:0] o0, bit fl, bit wr);
        bit  acc, full;
        mw_t h;
        @(negedge clock);
        in_valid = iv; out1_in = o1; out0_in = o0; flush = fl; word_ready = wr;
        #1;
        h.w = '0; h.f = 0;
        if (q.size() > 0) h = q[0];
        chk("in_ready", in_ready, exp_ready());
        chk("word_valid", word_valid, q.size() > 0);
        chk("word_out", word_out, h.w);
        chk("word_fill", word_fill, h.f);
        chk("fifo_level", fifo_level, q.size());
        acc  = iv && exp_ready();
        full = q.size() == N_DEPTH;
        @(posedge clock);
        if (wr && q.size() > 0) void'(q.pop_front());
        if (pend) begin
            if (!full) begin q.push_back(build()); cur.delete(); pend = 0; end
        end else begin
            if (acc) cur.push_back((int'(o1) << N_BITS) | int'(o0));
            if (cur.size() == N_PACK) begin
                q.push_back(build()); cur.delete();
            end else if (fl && cur.size() > 0) begin
                if (!full) begin q.push_back(build()); cur.delete(); end
                else pend = 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 0; in_valid = 0; flush = 0; word_ready = 0;
        @(posedge clock);
        #1;
        reset_n = 1;
        cur.delete(); q.delete(); pend = 0;
    endtask

    task automatic rnd_samples(int n, bit wr);
        for (int i = 0; i < n; i++) step(1, 1'($urandom), N_BITS'($urandom), 0, wr);
    endtask

    initial begin
        do_reset();
        chk("rst_level", fifo_level, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_word", word_out, 0);
        chk("rst_fill", word_fill, 0);
        chk("rst_ready", in_ready, 1);
        // full word with immediate pop
        step(1, 1, 2, 0, 1); step(1, 0, 3, 0, 1); step(1, 1, 0, 0, 1); step(1, 0, 1, 0, 1);
        #1;
        chk("fw_valid", word_valid, 1);
        chk("fw_word", word_out[WORD_W-1:0], 12'h31E);
        chk("fw_fill", word_fill, 4);
`ifdef PACKER_PARITY_EN
        chk("fw_parity", word_out[WORD_W], 0);
`endif
        step(0, 0, 0, 0, 1);
        #1;
        chk("fw_level", fifo_level, 0);
        // partial flush, separate and same-cycle
        step(1, 1, 2, 0, 0); step(1, 0, 3, 0, 0); step(0, 0, 0, 1, 0);
        #1;
        chk("pf_word", word_out[WORD_W-1:0], 12'h01E);
        chk("pf_fill", word_fill, 2);
        step(0, 0, 0, 0, 1);
        step(1, 1, 2, 0, 0); step(1, 0, 3, 0, 0); step(1, 1, 0, 1, 0);
        #1;
        chk("sf_word", word_out[WORD_W-1:0], 12'h11E);
        chk("sf_fill", word_fill, 3);
        step(0, 0, 0, 0, 1);
        // backpressure
        rnd_samples(16, 0);
        #1;
        chk("bp_level4", fifo_level, 4);
        rnd_samples(3, 0);
        #1;
        chk("bp_ready_low", in_ready, 0);
        step(1, 1, 3, 0, 1);
        #1;
        chk("bp_level3", fifo_level, 3);
        chk("bp_ready_high", in_ready, 1);
        repeat (4) step(0, 0, 0, 0, 1);
        // pending flush
        do_reset();
        rnd_samples(18, 0);
        step(0, 0, 0, 1, 0);
        #1;
        chk("pend_ready", in_ready, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        #1;
        chk("pend_level3", fifo_level, 3);
        step(0, 0, 0, 0, 0);
        #1;
        chk("pend_level4", fifo_level, 4);
        chk("pend_back", in_ready, 1);
        repeat (5) step(0, 0, 0, 0, 1);
        // reset mid-operation
        rnd_samples(11, 0);
        #1;
        chk("mid_level", fifo_level, 2);
        do_reset();
        chk("mr_level", fifo_level, 0);
        chk("mr_valid", word_valid, 0);
        chk("mr_word", word_out, 0);
        chk("mr_ready", in_ready, 1);
        rnd_samples(4, 0);
        step(0, 0, 0, 0, 1);
        // parity / single-sample flush
        do_reset();
        step(1, 0, 1, 0, 0); step(0, 0, 0, 1, 0);
        #1;
`ifdef PACKER_PARITY_EN
        chk("par_word", word_out, 13'h1001);
`else
        chk("one_word", word_out, 12'h001);
`endif
        chk("one_fill", word_fill, 1);
        step(0, 0, 0, 0, 1);
        // randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(3) != 0, 1'($urandom), N_BITS'($urandom),
                 $urandom_range(7) == 0, 1'($urandom));
        repeat (8) step(0, 0, 0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
